// File: rtl/resp_framer.sv
// Response framer: wraps responses and acks into host-protocol blocks
// (LEN, SEQ, payload, CRC16 hi/lo, sync) and streams them byte-wise.
module resp_framer #(
  parameter int unsigned LEN_BITS    = 8,
  parameter int unsigned MAX_PAYLOAD = 59,
  parameter logic [7:0]  SYNC_BYTE   = 8'h7e
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEN_BITS-1:0] len_fifo_data,
  input  logic                len_fifo_empty,
  output logic                len_fifo_rd_en,
  input  logic [7:0]          ring_data,
  input  logic                ring_empty,
  output logic                ring_rd_en,
  input  logic [3:0]          seq_in,
  input  logic                ack_req,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                overflow_err
);

  localparam int unsigned CRC_W    = 16;
  localparam int unsigned FRAME_OH = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_SEQ, S_PAYLOAD, S_CRC_HI, S_CRC_LO, S_SYNC, S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] n_q, n_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]          seq_q, seq_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic                ack_pending_q, ack_pending_d;
  logic                overflow_q, overflow_d;

  // CRC-16/MCRF4XX byte update (reflected poly 0x8408)
  function automatic logic [CRC_W-1:0] crc_upd(input logic [CRC_W-1:0] c,
                                               input logic [7:0] b);
    logic [CRC_W-1:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      cnt_q         <= '0;
      seq_q         <= '0;
      crc_q         <= 16'hffff;
      ack_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      cnt_q         <= cnt_d;
      seq_q         <= seq_d;
      crc_q         <= crc_d;
      ack_pending_q <= ack_pending_d;
      overflow_q    <= overflow_d;
    end
  end

  // Next-state, byte selection, FIFO pops and CRC accumulation
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    cnt_d          = cnt_q;
    seq_d          = seq_q;
    crc_d          = crc_q;
    ack_pending_d  = ack_pending_q | ack_req;
    overflow_d     = 1'b0;
    len_fifo_rd_en = 1'b0;
    ring_rd_en     = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (!len_fifo_empty) begin
          len_fifo_rd_en = 1'b1;
          n_d            = len_fifo_data;
          if (len_fifo_data > LEN_BITS'(MAX_PAYLOAD)) begin
            state_d    = S_DROP;
            cnt_d      = len_fifo_data;
            overflow_d = 1'b1;
          end else begin
            state_d       = S_LEN;
            seq_d         = seq_in;
            ack_pending_d = ack_req;
          end
        end else if (ack_pending_q) begin
          state_d       = S_LEN;
          n_d           = '0;
          seq_d         = seq_in;
          ack_pending_d = ack_req;
        end
      end
      S_LEN: begin
        tx_valid = 1'b1;
        tx_data  = 8'(n_q) + 8'(FRAME_OH);
        if (tx_ready) begin
          crc_d   = crc_upd(crc_q, tx_data);
          state_d = S_SEQ;
        end
      end
      S_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = {4'h1, seq_q};
        if (tx_ready) begin
          crc_d   = crc_upd(crc_q, tx_data);
          cnt_d   = n_q;
          state_d = (n_q == '0) ? S_CRC_HI : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        tx_valid = !ring_empty;
        tx_data  = ring_data;
        if (!ring_empty && tx_ready) begin
          ring_rd_en = 1'b1;
          crc_d      = crc_upd(crc_q, tx_data);
          cnt_d      = cnt_q - LEN_BITS'(1);
          if (cnt_q == LEN_BITS'(1)) state_d = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = crc_q[15:8];
        if (tx_ready) state_d = S_CRC_LO;
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = crc_q[7:0];
        if (tx_ready) state_d = S_SYNC;
      end
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) begin
          state_d = S_IDLE;
          crc_d   = 16'hffff;
        end
      end
      S_DROP: begin
        if (!ring_empty) begin
          ring_rd_en = 1'b1;
          cnt_d      = cnt_q - LEN_BITS'(1);
          if (cnt_q == LEN_BITS'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_resp_framer.sv
// Bench for resp_framer: bench-owned FWFT FIFOs, frame-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_resp_framer;

  localparam int unsigned MAXP = 59;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] len_fifo_data;
  logic       len_fifo_empty;
  logic       len_fifo_rd_en;
  logic [7:0] ring_data;
  logic       ring_empty;
  logic       ring_rd_en;
  logic [3:0] seq_in;
  logic       ack_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overflow_err;

  always #5 clk = ~clk;

  resp_framer #(.LEN_BITS(8), .MAX_PAYLOAD(59), .SYNC_BYTE(8'h7e)) dut (
    .clk(clk), .rst_n(rst_n),
    .len_fifo_data(len_fifo_data), .len_fifo_empty(len_fifo_empty),
    .len_fifo_rd_en(len_fifo_rd_en),
    .ring_data(ring_data), .ring_empty(ring_empty), .ring_rd_en(ring_rd_en),
    .seq_in(seq_in), .ack_req(ack_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow_err(overflow_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // bench FIFOs (what the DUT sees) and model copies (what the DUT should consume)
  logic [7:0] len_q[$], ring_q[$], m_len[$], m_ring[$];
  logic [7:0] cap[$], fbytes[$], ref2[$], tmp[$];
  logic       ring_hold;

  // model state: mode 0 idle, 1 framing, 2 dropping
  int         mode, fn, pos, rem;
  logic [3:0] fseq;
  logic       ack_pend, ovf_pend, pop_ring, pop_len, prev_stall;
  logic [7:0] prev_data;
  int         ring_pops, ovf_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // CRC-16/MCRF4XX, bit-serial LSB first
  function automatic logic [15:0] crc16(input logic [7:0] d[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hffff;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic void refresh();
    len_fifo_empty = (len_q.size() == 0);
    len_fifo_data  = (len_q.size() != 0) ? len_q[0] : 8'h00;
    ring_empty     = (ring_q.size() == 0) || ring_hold;
    ring_data      = (ring_q.size() != 0) ? ring_q[0] : 8'h00;
  endfunction

  function automatic void push_ring(input logic [7:0] b);
    ring_q.push_back(b);
    m_ring.push_back(b);
  endfunction

  function automatic void push_len(input logic [7:0] n);
    len_q.push_back(n);
    m_len.push_back(n);
  endfunction

  function automatic void model_reset();
    mode = 0; ack_pend = 1'b0; ovf_pend = 1'b0; prev_stall = 1'b0;
    fbytes.delete();
  endfunction

  function automatic void start_frame(input int n);
    mode = 1; fn = n; pos = 0; fseq = seq_in;
    fbytes.delete();
  endfunction

  // One cycle of the reference model, evaluated at the falling edge
  task automatic step();
    logic       e_valid, e_busy, e_rre, e_lre, e_ovf, is_pay;
    logic [7:0] e_data;
    logic [15:0] c;
    int         n;
    pop_ring = 1'b0;
    pop_len  = 1'b0;
    if (!rst_n) begin
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ring_rd_en", ring_rd_en, 0);
      chk("rst_len_rd_en", len_fifo_rd_en, 0);
      return;
    end
    e_valid = 1'b0; e_busy = (mode != 0); e_rre = 1'b0; e_lre = 1'b0;
    e_ovf = 1'b0; is_pay = 1'b0; e_data = 8'h00;

    if (mode == 1) begin
      if (pos == 0) begin e_valid = 1'b1; e_data = 8'(fn + 5); end
      else if (pos == 1) begin e_valid = 1'b1; e_data = {4'h1, fseq}; end
      else if (pos < fn + 2) begin
        is_pay  = 1'b1;
        e_valid = !ring_empty;
        e_data  = (m_ring.size() != 0) ? m_ring[0] : 8'h00;
      end else if (pos == fn + 2) begin
        c = crc16(fbytes); e_valid = 1'b1; e_data = c[15:8];
      end else if (pos == fn + 3) begin
        c = crc16(fbytes); e_valid = 1'b1; e_data = c[7:0];
      end else begin e_valid = 1'b1; e_data = 8'h7e; end
      e_rre = is_pay && e_valid && tx_ready;
    end else if (mode == 2) begin
      e_rre = !ring_empty;
      e_ovf = ovf_pend;
    end else begin
      e_lre = (m_len.size() != 0);
    end

    chk("tx_valid", tx_valid, e_valid);
    chk("busy", busy, e_busy);
    chk("ring_rd_en", ring_rd_en, e_rre);
    chk("len_rd_en", len_fifo_rd_en, e_lre);
    chk("overflow_err", overflow_err, e_ovf);
    if (e_valid && tx_valid) chk("tx_data", tx_data, e_data);
    if (prev_stall) chk("tx_data_hold", tx_data, prev_data);
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;

    if (tx_valid && tx_ready) cap.push_back(tx_data);
    if (ring_rd_en) ring_pops++;
    if (overflow_err) ovf_cnt++;
    pop_len  = len_fifo_rd_en && (len_q.size() != 0);
    pop_ring = ring_rd_en && (ring_q.size() != 0);

    if (mode == 1) begin
      ack_pend = ack_pend | ack_req;
      if (e_valid && tx_ready) begin
        if (is_pay && m_ring.size() != 0) void'(m_ring.pop_front());
        if (pos < fn + 2) fbytes.push_back(e_data);
        pos++;
        if (pos == fn + 5) mode = 0;
      end
    end else if (mode == 2) begin
      ack_pend = ack_pend | ack_req;
      ovf_pend = 1'b0;
      if (e_rre) begin
        if (m_ring.size() != 0) void'(m_ring.pop_front());
        rem--;
        if (rem == 0) mode = 0;
      end
    end else begin
      if (m_len.size() != 0) begin
        n = int'(m_len.pop_front());
        if (n > int'(MAXP)) begin
          mode = 2; rem = n; ovf_pend = 1'b1;
          ack_pend = ack_pend | ack_req;
        end else begin
          start_frame(n);
          ack_pend = ack_req;
        end
      end else if (ack_pend) begin
        start_frame(0);
        ack_pend = ack_req;
      end else begin
        ack_pend = ack_req;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    if (pop_len) void'(len_q.pop_front());
    if (pop_ring) void'(ring_q.pop_front());
    #1;
    refresh();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (mode == 0 && m_len.size() == 0 && len_q.size() == 0 && !ack_pend) break;
      tick();
    end
    if (i == budget) fail_msg(name);
    tick();
    tick();
  endtask

  task automatic chk_cap(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, cap.size(), e.size());
    if (cap.size() == e.size())
      foreach (e[k]) chk(name, cap[k], e[k]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[$];
    logic [15:0] c;
    int held, hc, n;

    rst_n = 1'b0; seq_in = 4'h0; ack_req = 1'b0; tx_ready = 1'b0; ring_hold = 1'b0;
    ring_pops = 0; ovf_cnt = 0; fn = 0; pos = 0; rem = 0; fseq = 4'h0;
    prev_data = 8'h00; pop_ring = 1'b0; pop_len = 1'b0;
    model_reset();
    refresh();
    #1;
    chk("reset_tx_data", tx_data, 0);
    chk("reset_overflow", overflow_err, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // pin the reference CRC
    e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_check_value", crc16(e), 16'h6f91);
    e = '{8'h05, 8'h10};
    chk("crc_ack_seq0", crc16(e), 16'h9e81);

    // 1: ack block
    tx_ready = 1'b1; cap.delete();
    ack_req = 1'b1; tick(); ack_req = 1'b0;
    wait_idle(50, "ack_idle");
    e = '{8'h05, 8'h10, 8'h9e, 8'h81, 8'h7e};
    chk_cap("ack_frame", e);
    chk("ack_busy_after", busy, 0);

    // 2: 3-byte response
    seq_in = 4'h5; cap.delete(); ring_pops = 0;
    push_ring(8'h00); push_ring(8'h0a); push_ring(8'h01); push_len(8'd3); refresh();
    wait_idle(50, "resp_idle");
    e = '{8'h08, 8'h15, 8'h00, 8'h0a, 8'h01};
    c = crc16(e);
    e.push_back(c[15:8]); e.push_back(c[7:0]); e.push_back(8'h7e);
    chk_cap("resp_frame", e);
    chk("resp_ring_pops", ring_pops, 3);
    ref2 = cap;

    // 3: same frame under backpressure and a mid-payload ring stall
    cap.delete(); held = 0; hc = 0;
    push_ring(8'h00); push_ring(8'h0a); push_ring(8'h01); push_len(8'd3); refresh();
    for (int i = 0; i < 300; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (held == 0 && cap.size() >= 3) begin held = 1; hc = 4; end
      ring_hold = (hc > 0);
      if (hc > 0) hc--;
      refresh();
      tick();
      if (cap.size() == 8 && mode == 0) break;
    end
    ring_hold = 1'b0; tx_ready = 1'b1; refresh();
    wait_idle(50, "stall_idle");
    chk("stall_applied", held, 1);
    chk_cap("stall_frame", ref2);

    // 4: oversize response dropped, next one framed
    cap.delete(); ring_pops = 0; ovf_cnt = 0;
    for (int i = 0; i < 60; i++) push_ring(8'($urandom));
    push_len(8'd60);
    push_ring(8'ha5); push_len(8'd1); refresh();
    wait_idle(500, "drop_idle");
    chk("drop_ovf_pulses", ovf_cnt, 1);
    chk("drop_ring_pops", ring_pops, 61);
    chk("drop_next_len", cap.size(), 6);
    if (cap.size() == 6) begin
      chk("drop_next_b0", cap[0], 8'h06);
      chk("drop_next_b2", cap[2], 8'ha5);
      chk("drop_next_b5", cap[5], 8'h7e);
    end

    // 5: ack raised while a response is queued -> response only
    cap.delete();
    push_ring(8'h11); push_ring(8'h22); push_len(8'd2); refresh();
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    push_ring(8'h33); push_len(8'd1); refresh();
    ack_req = 1'b1; tick(); ack_req = 1'b0;
    wait_idle(100, "ackmerge_idle");
    repeat (5) tick();
    chk("ackmerge_bytes", cap.size(), 13);
    if (cap.size() == 13) chk("ackmerge_len2", cap[7], 8'h06);

    // 6: reset during payload, restart consumes the leftover ring bytes
    cap.delete();
    for (int i = 0; i < 10; i++) push_ring(8'(i * 7 + 3));
    push_len(8'd10); refresh();
    n = 0;
    while (cap.size() < 4 && n < 50) begin tick(); n++; end
    if (n == 50) fail_msg("rst_reach_payload");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ring_rd_en", ring_rd_en, 0);
    chk("midrst_len_rd_en", len_fifo_rd_en, 0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    cap.delete();
    push_len(8'd8); refresh();
    wait_idle(100, "postrst_idle");
    chk("postrst_bytes", cap.size(), 13);
    if (cap.size() == 13) begin
      chk("postrst_len", cap[0], 8'h0d);
      tmp.delete();
      for (int i = 0; i < 10; i++) tmp.push_back(cap[i]);
      c = crc16(tmp);
      chk("postrst_crc", {cap[10], cap[11]}, c);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tx_ready  = ($urandom_range(0, 3) != 0);
      ring_hold = ($urandom_range(0, 7) == 0);
      seq_in    = 4'($urandom);
      ack_req   = ($urandom_range(0, 24) == 0);
      if (len_q.size() < 2 && $urandom_range(0, 9) == 0) begin
        n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70))
                                        : int'($urandom_range(0, MAXP));
        for (int k = 0; k < n; k++) push_ring(8'($urandom));
        push_len(8'(n));
      end
      refresh();
      tick();
    end
    ack_req = 1'b0; ring_hold = 1'b0; tx_ready = 1'b1; refresh();
    wait_idle(2000, "random_drain");
    chk("random_ring_drained", ring_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
